text_fetch_unit: RTL and testbench

Instruction-fetch initiator for the program text memory bus. It sits between the core's fetch stage and the text memory bus responder. It issues in-order word reads from a sequential fetch PC and keeps up to QUEUE_DEPTH requests in flight against a bus with arbitrary latency and `wait_req` stalls. It buffers returned words with their PCs for the core and discards stale responses after a redirect.

---
 rtl/text_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_text_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_fetch_unit.sv
// Instruction-fetch initiator: issues in-order word reads from a sequential PC,
// tracks in-flight requests, and buffers returned {pc, word} pairs for the core.
module text_fetch_unit #(
   parameter int          QUEUE_DEPTH = 2,
   parameter logic [31:0] RESET_PC    = 32'h0040_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        bus_read_enable,
   output logic [31:0] bus_address,
   input  logic [31:0] bus_read_data,
   input  logic        bus_wait_req,
   input  logic        bus_valid,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);
   localparam int          PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int          CW      = $clog2(QUEUE_DEPTH + 1);
   localparam int          DW      = CW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

   // Handshakes: a bus request transfers on an edge with bus_read_enable=1 and
   // bus_wait_req=0; an instruction transfers on an edge with inst_valid=1 and inst_ready=1.

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          pending_q, pending_d;
   logic [31:0]   req_addr_q, req_addr_d;
   logic [31:0]   if_pc_q [QUEUE_DEPTH];
   logic [31:0]   if_pc_d [QUEUE_DEPTH];
   logic [PW-1:0] if_rd_q, if_rd_d, if_wr_q, if_wr_d;
   logic [CW-1:0] if_cnt_q, if_cnt_d;
   logic [31:0]   iq_pc_q [QUEUE_DEPTH];
   logic [31:0]   iq_pc_d [QUEUE_DEPTH];
   logic [31:0]   iq_word_q [QUEUE_DEPTH];
   logic [31:0]   iq_word_d [QUEUE_DEPTH];
   logic [PW-1:0] iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;
   logic [CW-1:0] iq_cnt_q, iq_cnt_d;
   logic [DW-1:0] discard_q, discard_d;

   logic          accept, held, push, pop;
   logic [31:0]   resp_pc, next_pc;
   logic [CW:0]   occ;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(QUEUE_DEPTH - 1)) return '0;
      return p + PW'(1);
   endfunction

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pending_d  = pending_q;
      req_addr_d = req_addr_q;
      if_pc_d    = if_pc_q;
      if_rd_d    = if_rd_q;
      if_wr_d    = if_wr_q;
      iq_pc_d    = iq_pc_q;
      iq_word_d  = iq_word_q;
      iq_rd_d    = iq_rd_q;
      iq_wr_d    = iq_wr_q;
      iq_cnt_d   = iq_cnt_q;
      discard_d  = discard_q;
      push       = 1'b0;
      pop        = 1'b0;
      accept     = pending_q & ~bus_wait_req;
      held       = pending_q & bus_wait_req;
      // A response may belong to the request being accepted on this very edge.
      resp_pc    = (if_cnt_q == '0) ? req_addr_q : if_pc_q[if_rd_q];

      if (accept) begin
         if_pc_d[if_wr_q] = req_addr_q;
         if_wr_d          = ptr_inc(if_wr_q);
      end
      if (bus_valid) if_rd_d = ptr_inc(if_rd_q);
      if_cnt_d = if_cnt_q + CW'(accept) - CW'(bus_valid);

      if (redirect) begin
         iq_rd_d   = '0;
         iq_wr_d   = '0;
         iq_cnt_d  = '0;
         discard_d = DW'(if_cnt_q) + DW'(accept) + DW'(held) - DW'(bus_valid);
      end else begin
         if (bus_valid && discard_q != '0) discard_d = discard_q - DW'(1);
         push = bus_valid & (discard_q == '0);
         pop  = (iq_cnt_q != '0) & inst_ready;
         if (push) begin
            iq_pc_d[iq_wr_q]   = resp_pc;
            iq_word_d[iq_wr_q] = bus_read_data;
            iq_wr_d            = ptr_inc(iq_wr_q);
         end
         if (pop) iq_rd_d = ptr_inc(iq_rd_q);
         iq_cnt_d = iq_cnt_q + CW'(push) - CW'(pop);
      end

      // A request issued on a redirect edge already belongs to the new stream.
      next_pc    = redirect ? (redirect_pc & ~32'd3) : fetch_pc_q;
      fetch_pc_d = next_pc;
      occ        = {1'b0, if_cnt_d} + {1'b0, iq_cnt_d};
      if (!held) begin
         pending_d = 1'b0;
         if (occ < DEPTH_W) begin
            pending_d  = 1'b1;
            req_addr_d = next_pc;
            fetch_pc_d = next_pc + 32'd4;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         pending_q  <= 1'b0;
         req_addr_q <= '0;
         if_pc_q    <= '{default: '0};
         if_rd_q    <= '0;
         if_wr_q    <= '0;
         if_cnt_q   <= '0;
         iq_pc_q    <= '{default: '0};
         iq_word_q  <= '{default: '0};
         iq_rd_q    <= '0;
         iq_wr_q    <= '0;
         iq_cnt_q   <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pending_q  <= pending_d;
         req_addr_q <= req_addr_d;
         if_pc_q    <= if_pc_d;
         if_rd_q    <= if_rd_d;
         if_wr_q    <= if_wr_d;
         if_cnt_q   <= if_cnt_d;
         iq_pc_q    <= iq_pc_d;
         iq_word_q  <= iq_word_d;
         iq_rd_q    <= iq_rd_d;
         iq_wr_q    <= iq_wr_d;
         iq_cnt_q   <= iq_cnt_d;
         discard_q  <= discard_d;
      end
   end

   assign bus_read_enable = pending_q;
   assign bus_address     = req_addr_q;
   assign inst_valid      = (iq_cnt_q != '0);
   assign inst            = iq_word_q[iq_rd_q];
   assign inst_pc         = iq_pc_q[iq_rd_q];

endmodule

// File: tb/tb_text_fetch_unit.sv
// Bench for text_fetch_unit: randomized bus responder and core, scoreboard of the
// expected sequential instruction stream restarted on every redirect or reset.
module tb_text_fetch_unit;
   localparam int          D        = 2;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        bus_read_enable;
   logic [31:0] bus_address;
   logic [31:0] bus_read_data;
   logic        bus_wait_req;
   logic        bus_valid;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   text_fetch_unit #(.QUEUE_DEPTH(D), .RESET_PC(RESET_PC)) dut (
      .clock(clock), .reset(reset),
      .bus_read_enable(bus_read_enable), .bus_address(bus_address),
      .bus_read_data(bus_read_data), .bus_wait_req(bus_wait_req), .bus_valid(bus_valid),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_consumed = 0;

   // stimulus knobs
   int lat_min = 0, lat_max = 0, wait_pct = 0, ready_pct = 100, redir_pm = 0;
   logic [31:0] force_wait_addr = 32'hFFFF_FFFF;
   int          force_wait_n = 0;
   logic        force_redir = 1'b0;
   logic [31:0] force_redir_pc = '0;
   logic [31:0] watch_addr = 32'hFFFF_FFFF;
   int          watch_cnt = 0;

   // bus responder state: accepted addresses with their due cycle
   logic [31:0] acc_q[$];
   int          due_q[$];
   int          last_due = 0;

   // scoreboard: expected delivered {pc, word}
   logic [63:0] exp_q[$];
   logic [31:0] exp_next;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_restart(input logic [31:0] pc);
      exp_q.delete();
      exp_next = pc & ~32'd3;
   endtask

   task automatic exp_topup();
      while (exp_q.size() < 16) begin
         exp_q.push_back({exp_next, data_of(exp_next)});
         exp_next = exp_next + 32'd4;
      end
   endtask

   // One cycle of core and bus stimulus, applied at the falling edge.
   task automatic step();
      int lat, due;
      logic acc;
      @(negedge clock);
      cyc++;
      inst_ready = ($urandom_range(99) < ready_pct);
      redirect   = 1'b0;
      if (force_redir || ($urandom_range(999) < redir_pm)) begin
         redirect    = 1'b1;
         redirect_pc = force_redir ? force_redir_pc
                                   : (32'h0040_0000 + ($urandom_range(4095) << 2) + $urandom_range(3));
         force_redir = 1'b0;
         exp_restart(redirect_pc);
      end
      exp_topup();
      if (bus_read_enable && bus_address == force_wait_addr && force_wait_n > 0) begin
         bus_wait_req = 1'b1;
         force_wait_n--;
      end else begin
         bus_wait_req = bus_read_enable && ($urandom_range(99) < wait_pct);
      end
      acc = bus_read_enable && !bus_wait_req;
      if (acc) begin
         lat = $urandom_range(lat_max, lat_min);
         due = cyc + lat;
         if (due < last_due) due = last_due;
         last_due = due;
         acc_q.push_back(bus_address);
         due_q.push_back(due);
         if (bus_address == watch_addr) watch_cnt++;
      end
      bus_valid     = 1'b0;
      bus_read_data = '0;
      if (acc_q.size() > 0 && due_q[0] <= cyc) begin
         bus_valid     = 1'b1;
         bus_read_data = data_of(acc_q[0]);
         void'(acc_q.pop_front());
         void'(due_q.pop_front());
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2;
      reset        = 1'b0;
      bus_valid    = 1'b0;
      bus_wait_req = 1'b0;
      redirect     = 1'b0;
      inst_ready   = 1'b0;
      #1;
      chk("async_rst_bus_en", {31'd0, bus_read_enable}, 32'd0);
      chk("async_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      acc_q.delete();
      due_q.delete();
      last_due = 0;
      exp_restart(RESET_PC);
      exp_topup();
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Monitor: compares the presented instruction against the scoreboard head.
   initial begin
      forever begin
         @(negedge clock);
         #4;
         if (reset && !redirect) begin
            if (bus_valid && dut.discard_q == '0)
               chk("no_push_into_full", {31'd0, (dut.iq_cnt_q < D) || (inst_valid && inst_ready)}, 32'd1);
            if (inst_valid) begin
               if (exp_q.size() == 0) begin
                  chk("exp_queue_empty", inst_pc, 32'hDEAD_BEEF);
               end else begin
                  chk("inst_pc", inst_pc, exp_q[0][63:32]);
                  chk("inst_word", inst, exp_q[0][31:0]);
                  if (inst_ready) begin
                     void'(exp_q.pop_front());
                     n_consumed++;
                  end
               end
            end
         end
      end
   end

   initial begin
      int k;
      reset = 1'b0; bus_valid = 1'b0; bus_wait_req = 1'b0; bus_read_data = '0;
      inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      exp_restart(RESET_PC);
      exp_topup();
      #1;
      chk("rst_bus_en", {31'd0, bus_read_enable}, 32'd0);
      chk("rst_bus_addr", bus_address, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // back-to-back fetch with zero latency
      lat_min = 0; lat_max = 0; wait_pct = 0; ready_pct = 100;
      step();
      chk("first_req_en", {31'd0, bus_read_enable}, 32'd1);
      chk("first_req_addr", bus_address, 32'h0040_0000);
      step();
      chk("b2b_addr1", bus_address, 32'h0040_0004);
      chk("b2b_pc0", inst_pc, 32'h0040_0000);
      step();
      chk("b2b_addr2", bus_address, 32'h0040_0008);
      chk("b2b_pc1", inst_pc, 32'h0040_0004);
      repeat (5) step();

      // credit limit: latency 3, core stalled
      do_reset();
      lat_min = 3; lat_max = 3; ready_pct = 0;
      watch_cnt = 0;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus_read_enable && !bus_wait_req) k++;
      end
      chk("credit_issue_cnt", k, 32'd2);
      chk("credit_en_idle", {31'd0, bus_read_enable}, 32'd0);
      chk("credit_head_pc", inst_pc, 32'h0040_0000);
      ready_pct = 100;
      step();
      ready_pct = 0;
      step();
      chk("credit_next_pc", inst_pc, 32'h0040_0004);
      ready_pct = 100;
      repeat (8) step();

      // request held by wait_req for 4 cycles
      do_reset();
      lat_min = 0; lat_max = 0; ready_pct = 100;
      force_wait_addr = 32'h0040_0008; force_wait_n = 4;
      watch_addr = 32'h0040_0008; watch_cnt = 0;
      step(); step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_en", {31'd0, bus_read_enable}, 32'd1);
         chk("hold_addr", bus_address, 32'h0040_0008);
      end
      repeat (4) step();
      chk("hold_accept_once", watch_cnt, 32'd1);
      force_wait_addr = 32'hFFFF_FFFF;

      // redirect with one request in flight and one held
      do_reset();
      lat_min = 4; lat_max = 4; ready_pct = 100;
      force_wait_addr = 32'h0040_0004; force_wait_n = 3;
      step(); step();
      force_redir = 1'b1; force_redir_pc = 32'h0040_0103;
      step();
      chk("redir_held_en", {31'd0, bus_read_enable}, 32'd1);
      chk("redir_held_addr", bus_address, 32'h0040_0004);
      k = 0;
      while (!inst_valid && k < 40) begin
         step();
         k++;
      end
      chk("redir_timeout", {31'd0, inst_valid}, 32'd1);
      chk("redir_first_pc", inst_pc, 32'h0040_0100);
      force_wait_addr = 32'hFFFF_FFFF;
      repeat (10) step();

      // random traffic with redirects and a reset in the middle
      lat_min = 0; lat_max = 4; wait_pct = 25; ready_pct = 70; redir_pm = 20;
      n_consumed = 0;
      repeat (1200) step();
      do_reset();
      step();
      chk("restart_addr", bus_address, RESET_PC);
      chk("restart_en", {31'd0, bus_read_enable}, 32'd1);
      repeat (1200) step();
      chk("progress", {31'd0, n_consumed > 200}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
